// File: rtl/block_averager.sv
// Collects WORDS samples per block and emits their sum and average; a flush
// closes a partial block early. One result register with valid/ready handoff.
module block_averager #(
  parameter int unsigned DW    = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic                          clk_2,
  input  logic                          rst,
  input  logic [DW-1:0]                 data_in,
  input  logic                          data_in_valid,
  input  logic                          flush,
  input  logic                          out_ready,
  output logic [DW+$clog2(WORDS)-1:0]   sum_out,
  output logic [DW-1:0]                 avg_out,
  output logic [3:0]                    count_out,
  output logic                          out_valid,
  output logic                          partial,
  output logic                          overrun
);

  localparam int unsigned LW = $clog2(WORDS);
  localparam int unsigned SW = DW + LW;
  localparam int unsigned NW = LW + 1;

  logic [LW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] avg_q, avg_d;
  logic [3:0]    count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic          partial_q, partial_d;
  logic          overrun_q, overrun_d;

  logic [SW-1:0] acc_add;
  logic [NW-1:0] n_words;
  logic          complete;
  logic          do_flush;
  logic          load;

  // Accumulate, close blocks, and manage the single-entry result register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    avg_d       = avg_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    partial_d   = partial_q;
    overrun_d   = overrun_q;

    acc_add  = data_in_valid ? acc_q + SW'(data_in) : acc_q;
    n_words  = NW'(cnt_q) + NW'(data_in_valid);
    complete = data_in_valid && (cnt_q == LW'(WORDS - 1));
    do_flush = flush && !complete && (n_words != '0);
    load     = complete || do_flush;

    if (data_in_valid) begin
      acc_d = acc_add;
      cnt_d = cnt_q + LW'(1);
    end

    if (load) begin
      acc_d       = '0;
      cnt_d       = '0;
      sum_d       = acc_add;
      avg_d       = complete ? DW'(acc_add >> LW) : '0;
      count_d     = complete ? 4'(WORDS) : 4'(n_words);
      partial_d   = !complete;
      out_valid_d = 1'b1;
      // A result still waiting when the next one lands is lost.
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_2) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      avg_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      partial_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      avg_q       <= avg_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      partial_q   <= partial_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sum_out   = sum_q;
  assign avg_out   = avg_q;
  assign count_out = count_q;
  assign out_valid = out_valid_q;
  assign partial   = partial_q;
  assign overrun   = overrun_q;

endmodule
